mul_div_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit that sits directly downstream of the register file. It consumes the two register read ports as operands and computes one result bit per cycle. It returns the result to the register file write port through a one-cycle writeEn pulse with the captured destination address. The controller pulses start and stalls on busy.

---
 rtl/mul_div_unit.sv | 143 ++++++++++++++
 tb/tb_mul_div_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: one result bit per clock, result written back
// to the register file through a one-cycle writeEn pulse.
module mul_div_unit #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  input  logic [REGBITS-1:0] dstIn,
  output logic               busy,
  output logic               done,
  output logic               writeEn,
  output logic [REGBITS-1:0] writeAddr,
  output logic [WIDTH-1:0]   writeData,
  output logic [WIDTH-1:0]   resultHi,
  output logic               divZero,
  output logic [1:0]         o_dbg_state
);

  // Handshake: start is taken only in IDLE; busy covers RUN/DZERO; done and
  // writeEn pulse together for exactly one cycle with the captured address.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DZERO, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [CW-1:0]        r_cnt;
  logic                 r_div, r_neg_res, r_neg_a;
  logic [WIDTH-1:0]     r_b, r_q;
  logic [WIDTH:0]       r_p;
  logic [REGBITS-1:0]   r_waddr;
  logic [WIDTH-1:0]     r_wdata, r_rhi;
  logic                 r_done, r_dz;

  logic                 w_accept, w_dz, w_last, w_sa, w_sb, w_ge;
  logic [WIDTH-1:0]     w_mag_a, w_mag_b, w_nq, w_res_lo, w_res_hi, w_quo, w_rem;
  logic [WIDTH:0]       w_addend, w_sum, w_sh, w_np;
  logic [WIDTH+1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_prod, w_prod_s;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_dz     = op[1] && (opB == '0);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_sa     = op[0] && opA[WIDTH-1];
  assign w_sb     = op[0] && opB[WIDTH-1];
  // The most negative value negates to itself, which reads correctly as unsigned.
  assign w_mag_a  = w_sa ? -opA : opA;
  assign w_mag_b  = w_sb ? -opB : opB;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_dz ? S_DZERO : S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DZERO: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Multiply step: conditional add then shift {p, q} right by one.
  // Divide step: shift remainder left pulling the next dividend bit, restore on borrow.
  always_comb begin
    w_addend = r_q[0] ? {1'b0, r_b} : '0;
    w_sum    = r_p + w_addend;
    w_sh     = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
    w_diff   = {1'b0, w_sh} - {2'b00, r_b};
    w_ge     = ~w_diff[WIDTH+1];
    if (r_div) begin
      w_np = w_ge ? w_diff[WIDTH:0] : w_sh;
      w_nq = {r_q[WIDTH-2:0], w_ge};
    end else begin
      w_np = {1'b0, w_sum[WIDTH:1]};
      w_nq = {w_sum[0], r_q[WIDTH-1:1]};
    end
    w_prod   = {w_np[WIDTH-1:0], w_nq};
    w_prod_s = r_neg_res ? -w_prod : w_prod;
    w_quo    = r_neg_res ? -w_nq : w_nq;
    w_rem    = r_neg_a ? -w_np[WIDTH-1:0] : w_np[WIDTH-1:0];
    w_res_lo = r_div ? w_quo : w_prod_s[WIDTH-1:0];
    w_res_hi = r_div ? w_rem : w_prod_s[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_div     <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_a   <= 1'b0;
      r_b       <= '0;
      r_q       <= '0;
      r_p       <= '0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_rhi     <= '0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= ((r_state == S_RUN) && w_last) || (r_state == S_DZERO);
      r_dz   <= (r_state == S_DZERO);
      if (w_accept) begin
        r_div     <= op[1];
        r_neg_res <= w_sa ^ w_sb;
        r_neg_a   <= w_sa;
        r_b       <= w_mag_b;
        r_q       <= w_dz ? opA : w_mag_a;
        r_p       <= '0;
        r_cnt     <= '0;
        r_waddr   <= dstIn;
      end else if (r_state == S_RUN) begin
        r_p   <= w_np;
        r_q   <= w_nq;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_wdata <= w_res_lo;
          r_rhi   <= w_res_hi;
        end
      end else if (r_state == S_DZERO) begin
        r_wdata <= '1;
        r_rhi   <= r_q;
      end
    end
  end

  assign busy        = (r_state == S_RUN) || (r_state == S_DZERO);
  assign done        = r_done;
  assign writeEn     = r_done;
  assign divZero     = r_dz;
  assign writeAddr   = r_waddr;
  assign writeData   = r_wdata;
  assign resultHi    = r_rhi;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected write-backs are queued at start
// and compared when writeEn fires.
module tb_mul_div_unit;

  localparam int W  = 16;
  localparam int RB = 4;
  localparam int EW = 1 + RB + 2 * W;

  logic          clk, reset, start;
  logic [1:0]    op;
  logic [W-1:0]  opA, opB;
  logic [RB-1:0] dstIn;
  logic          busy, done, writeEn, divZero;
  logic [RB-1:0] writeAddr;
  logic [W-1:0]  writeData, resultHi;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  mul_div_unit #(.WIDTH(W), .REGBITS(RB)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .dstIn(dstIn), .busy(busy), .done(done), .writeEn(writeEn),
    .writeAddr(writeAddr), .writeData(writeData), .resultHi(resultHi),
    .divZero(divZero), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [RB-1:0] d);
    logic [2*W-1:0] p;
    logic [W-1:0]   q, r;
    logic           dz;
    int             sa, sb;
    dz = 1'b0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    p  = '0;
    case (o)
      2'd0: p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      2'd1: p = 32'(sa * sb);
      default: begin
        if (b == '0) begin
          dz = 1'b1;
          p  = {a, {W{1'b1}}};
        end else begin
          if (o == 2'd2) begin
            q = a / b;
            r = a % b;
          end else begin
            q = 16'(sa / sb);
            r = 16'(sa % sb);
          end
          p = {r, q};
        end
      end
    endcase
    return {dz, d, p};
  endfunction

  // scoreboard: compare each write-back against the oldest expectation
  always @(negedge clk) begin
    if (writeEn) begin
      check("done_eq_we", done, 1'b1);
      if (exp_q.size() == 0) begin
        check("spurious_we", 1'b1, 1'b0);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("writeData", writeData, e[W-1:0]);
        check("resultHi", resultHi, e[2*W-1:W]);
        check("writeAddr", writeAddr, e[2*W+RB-1:2*W]);
        check("divZero", divZero, e[EW-1]);
      end
    end
  end

  // driver: issue one op, optionally with noise on inputs while it runs
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [RB-1:0] d, input bit noise);
    logic [EW-1:0] e;
    int k, busy_n, exp_lat;
    e = model(o, a, b, d);
    exp_lat = e[EW-1] ? 1 : W;
    @(negedge clk);
    op = o; opA = a; opB = b; dstIn = d; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    busy_n = 0;
    while (!done && k < 60) begin
      if (busy) busy_n++;
      opA   = W'($urandom_range(0, 65535));
      opB   = W'($urandom_range(0, 65535));
      dstIn = RB'($urandom_range(0, 15));
      op    = 2'($urandom_range(0, 3));
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("latency", 64'(k), 64'(exp_lat));
    check("busy_cycles", 64'(busy_n), 64'(exp_lat));
    @(negedge clk);
    check("done_cleared", {done, writeEn, divZero, busy}, 4'b0000);
    check("idle_state", dbg_state, 2'd0);
    check("hold_lo", writeData, e[W-1:0]);
    check("hold_hi", resultHi, e[2*W-1:W]);
  endtask

  initial begin
    logic [W-1:0] edge_v[6];
    edge_v = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};
    reset = 1'b0; start = 1'b0; op = 2'd0; opA = '0; opB = '0; dstIn = '0;
    repeat (2) @(negedge clk);
    check("rst_outs", {busy, done, writeEn, divZero, writeAddr, writeData, resultHi}, '0);
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b1;
    @(negedge clk);

    run_op(2'd0, 16'h1234, 16'h0010, 4'd3, 1'b0);
    run_op(2'd1, 16'hFFFD, 16'h0007, 4'd5, 1'b0);
    run_op(2'd1, 16'h8000, 16'h8000, 4'd6, 1'b0);
    run_op(2'd2, 16'h0064, 16'h0007, 4'd7, 1'b0);
    run_op(2'd3, 16'hFFF9, 16'h0002, 4'd8, 1'b0);
    run_op(2'd2, 16'h1234, 16'h0000, 4'd9, 1'b0);
    run_op(2'd3, 16'h8000, 16'hFFFF, 4'd10, 1'b1);
    run_op(2'd3, 16'h8001, 16'h0000, 4'd11, 1'b0);
    repeat (5) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      run_op(2'($urandom_range(0, 3)),
             (i < 8) ? edge_v[$urandom_range(0, 5)] : W'($urandom_range(0, 65535)),
             (i < 8) ? edge_v[$urandom_range(0, 5)] : W'($urandom_range(1, 65535)),
             RB'($urandom_range(0, 15)), i[0]);
    end

    // abort a multiply mid-way with reset
    @(negedge clk);
    op = 2'd0; opA = 16'h00FF; opB = 16'h0101; dstIn = 4'd12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_outs", {busy, done, writeEn, divZero, writeAddr, writeData, resultHi}, '0);
    check("abort_state", dbg_state, 2'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    run_op(2'd0, 16'h0003, 16'h0005, 4'd1, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
